kf76489_bus_interface: RTL and testbench

- CPU-side front end of the KF76489 PSG. Accepts byte writes through a chip-select/write-enable strobe pair and holds off the CPU with a READY wait of fixed length.
- Decodes each byte as a latch byte or a data byte, tracks the currently latched register, and drives the shared internal_data_bus.
- Issues one-cycle write strobes to the three tone generators, the attenuators and the noise generator.
- Sits directly upstream of the tone generators and feeds their internal_data_bus, write_frequency_h, write_frequency_l and write_attenuation inputs.

---
 rtl/kf76489_bus_interface.sv | 136 +++++++++++++
 tb/tb_kf76489_bus_interface.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kf76489_bus_interface.sv
// KF76489 CPU bus front end: accepts strobed byte writes, decodes latch/data
// bytes against the currently latched register, drives the bit-reversed
// internal data bus and issues one-cycle write strobes to the tone, attenuator
// and noise blocks. READY is held low for a fixed number of PSG ticks per write.
module kf76489_bus_interface #(
    parameter int unsigned WAIT_CYCLES = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clock_enable,
    input  logic       cs_n,
    input  logic       we_n,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic [7:0] internal_data_bus,
    output logic [2:0] write_frequency_h,
    output logic [2:0] write_frequency_l,
    output logic [3:0] write_attenuation,
    output logic       write_noise_control
);

    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_RELEASE,
        ST_IDLE,
        ST_STROBE,
        ST_WAIT
    } state_t;

    state_t     state_reg,   state_next;
    logic [7:0] byte_reg,    byte_next;
    logic [2:0] latched_reg, latched_next;
    logic [7:0] count_reg,   count_next;

    logic request;

    assign request = ~cs_n & ~we_n;

    // State and datapath registers; reset clears everything and parks in RELEASE
    // so a request held through reset is not taken until the CPU lets go.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= ST_RELEASE;
            byte_reg    <= 8'h00;
            latched_reg <= 3'd0;
            count_reg   <= 8'd0;
        end else begin
            state_reg   <= state_next;
            byte_reg    <= byte_next;
            latched_reg <= latched_next;
            count_reg   <= count_next;
        end
    end

    // Handshake sequencing: capture in IDLE, one strobe cycle, then a tick-paced
    // wait, then RELEASE until the request is dropped (no retrigger on a held strobe).
    always_comb begin
        state_next   = state_reg;
        byte_next    = byte_reg;
        latched_next = latched_reg;
        count_next   = count_reg;
        case (state_reg)
            ST_RELEASE: begin
                if (!request) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (request) begin
                    byte_next = data_in;
                    if (data_in[7]) begin
                        latched_next = data_in[6:4];
                    end
                    state_next = ST_STROBE;
                end
            end
            ST_STROBE: begin
                count_next = WAIT_INIT;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (clock_enable) begin
                    count_next = count_reg - 8'd1;
                    if (count_reg == 8'd1) begin
                        state_next = ST_RELEASE;
                    end
                end
            end
            default: begin
                state_next = ST_RELEASE;
            end
        endcase
    end

    // Strobe decode, active only during the single STROBE cycle. Latch bytes
    // select by their own register field; data bytes use the latched register
    // and only tone frequency registers take a data byte strobe.
    always_comb begin
        write_frequency_h   = 3'b000;
        write_frequency_l   = 3'b000;
        write_attenuation   = 4'b0000;
        write_noise_control = 1'b0;
        if (state_reg == ST_STROBE) begin
            if (byte_reg[7]) begin
                case (byte_reg[6:4])
                    3'd0:    write_frequency_h[0] = 1'b1;
                    3'd1:    write_attenuation[0] = 1'b1;
                    3'd2:    write_frequency_h[1] = 1'b1;
                    3'd3:    write_attenuation[1] = 1'b1;
                    3'd4:    write_frequency_h[2] = 1'b1;
                    3'd5:    write_attenuation[2] = 1'b1;
                    3'd6:    write_noise_control  = 1'b1;
                    default: write_attenuation[3] = 1'b1;
                endcase
            end else begin
                case (latched_reg)
                    3'd0:    write_frequency_l[0] = 1'b1;
                    3'd2:    write_frequency_l[1] = 1'b1;
                    3'd4:    write_frequency_l[2] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign ready = (state_reg == ST_RELEASE) || (state_reg == ST_IDLE);

    // Downstream blocks expect the byte with bit order reversed.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bus_rev
            assign internal_data_bus[gi] = byte_reg[7-gi];
        end
    endgenerate

endmodule

// File: tb/tb_kf76489_bus_interface.sv
// Bench for kf76489_bus_interface: directed and randomized byte writes checked
// against a transaction-level model of decode, bus value and READY timing.
module tb_kf76489_bus_interface;

    localparam int W = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clock_enable = 1'b0;
    logic       cs_n = 1'b1;
    logic       we_n = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       ready;
    logic [7:0] internal_data_bus;
    logic [2:0] write_frequency_h;
    logic [2:0] write_frequency_l;
    logic [3:0] write_attenuation;
    logic       write_noise_control;

    int tests = 0;
    int fails = 0;
    int ce_phase = 0;
    logic [2:0] model_lr = 3'd0;
    logic [7:0] model_bus = 8'h00;

    kf76489_bus_interface #(.WAIT_CYCLES(W)) dut (
        .clock               (clock),
        .reset               (reset),
        .clock_enable        (clock_enable),
        .cs_n                (cs_n),
        .we_n                (we_n),
        .data_in             (data_in),
        .ready               (ready),
        .internal_data_bus   (internal_data_bus),
        .write_frequency_h   (write_frequency_h),
        .write_frequency_l   (write_frequency_l),
        .write_attenuation   (write_attenuation),
        .write_noise_control (write_noise_control)
    );

    always #5 clock = ~clock;

    // {noise_ctrl, att[3:0], freq_l[2:0], freq_h[2:0]}
    wire [10:0] obs = {write_noise_control, write_attenuation, write_frequency_l, write_frequency_h};

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [10:0] exp_strobe(input logic [7:0] b, input logic [2:0] lr);
        logic [10:0] s;
        int r;
        s = 11'd0;
        if (b[7]) begin
            r = int'(b[6:4]);
            if (r == 7)          s[9]  = 1'b1;
            else if (r == 6)     s[10] = 1'b1;
            else if (r % 2 == 0) s[r/2] = 1'b1;
            else                 s[6 + r/2] = 1'b1;
        end else begin
            r = int'(lr);
            if (r % 2 == 0 && r < 6) s[3 + r/2] = 1'b1;
        end
        return s;
    endfunction

    task automatic get_ce(input int mode, output logic ce);
        if (mode == 0) ce = 1'b1;
        else if (mode == 1) begin
            ce = (ce_phase % 4 == 0);
            ce_phase++;
        end else ce = 1'($urandom_range(0, 1));
    endtask

    task automatic do_write(input logic [7:0] b, input int ce_mode, input bit hold,
                            input bit noisy, input string name);
        logic [10:0] exp_s;
        logic ce;
        int ticks, low;
        bit done;
        @(negedge clock);
        cs_n = 1'b1; we_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cs_n = 1'b0; we_n = 1'b0; data_in = b;
        get_ce(ce_mode, ce); clock_enable = ce;
        @(posedge clock); #1;
        exp_s = exp_strobe(b, model_lr);
        if (b[7]) model_lr = b[6:4];
        model_bus = rev8(b);
        tests++;
        if (ready !== 1'b0 || obs !== exp_s || internal_data_bus !== model_bus) begin
            fails++;
            $display("FAIL %s strobe: ready=%b strobes=%b bus=%h, want ready=0 strobes=%b bus=%h",
                     name, ready, obs, internal_data_bus, exp_s, model_bus);
        end
        ticks = 0; low = 1; done = 0;
        for (int iter = 0; iter < 4000 && !done; iter++) begin
            @(negedge clock);
            if (!hold) begin
                if (noisy) begin
                    cs_n = 1'($urandom_range(0, 1));
                    we_n = 1'($urandom_range(0, 1));
                    data_in = 8'($urandom);
                end else begin
                    cs_n = 1'b1; we_n = 1'b1;
                end
            end
            get_ce(ce_mode, ce); clock_enable = ce;
            @(posedge clock); #1;
            if (iter > 0 && ce) ticks++;
            tests++;
            if (ready !== (ticks >= W) || obs !== 11'd0 || internal_data_bus !== model_bus) begin
                fails++;
                $display("FAIL %s wait: cycle=%0d ready=%b strobes=%b bus=%h, want ready=%b strobes=0 bus=%h",
                         name, iter, ready, obs, internal_data_bus, (ticks >= W), model_bus);
            end
            if (ready === 1'b1) done = 1;
            else low++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s timeout: ready never returned high", name);
        end
        if (ce_mode == 0) begin
            tests++;
            if (low != 1 + W) begin
                fails++;
                $display("FAIL %s low_len: got %0d cycles, want %0d", name, low, 1 + W);
            end
        end
        $display("[TB] %s: byte=%h bus=%h strobes=%b ready_low=%0d ce_mode=%0d hold=%0d",
                 name, b, model_bus, exp_s, low, ce_mode, hold);
        if (hold) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clock);
                clock_enable = 1'($urandom_range(0, 1));
                @(posedge clock); #1;
                tests++;
                if (ready !== 1'b1 || obs !== 11'd0 || internal_data_bus !== model_bus) begin
                    fails++;
                    $display("FAIL %s retrigger: ready=%b strobes=%b bus=%h, want ready=1 strobes=0 bus=%h",
                             name, ready, obs, internal_data_bus, model_bus);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; cs_n = 1'b1; we_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if (ready !== 1'b1 || obs !== 11'd0 || internal_data_bus !== 8'h00) begin
            fails++;
            $display("FAIL reset_state: ready=%b strobes=%b bus=%h, want 1/0/00", ready, obs, internal_data_bus);
        end
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        tests++;
        if (ready !== 1'b1 || obs !== 11'd0 || internal_data_bus !== 8'h00) begin
            fails++;
            $display("FAIL reset_release: ready=%b strobes=%b bus=%h, want 1/0/00", ready, obs, internal_data_bus);
        end
        model_lr = 3'd0; model_bus = 8'h00;
        $display("[TB] reset: ready=%b bus=%h", ready, internal_data_bus);
    endtask

    task automatic test_tone_freq();
        do_write(8'h8A, 0, 0, 0, "tone_latch");
        do_write(8'h3F, 0, 0, 0, "tone_data");
    endtask

    task automatic test_attenuation();
        do_write(8'h9F, 0, 0, 0, "att_latch");
        do_write(8'h05, 0, 0, 0, "att_data_nostrobe");
        do_write(8'h05, 0, 0, 0, "att_data_again");
    endtask

    task automatic test_noise();
        do_write(8'hE4, 0, 0, 0, "noise_ctrl");
        do_write(8'hF0, 0, 0, 0, "noise_att");
    endtask

    task automatic test_slow_ce_hold();
        do_write(8'hA3, 1, 1, 0, "slow_ce_hold");
        do_write(8'h12, 1, 0, 0, "slow_ce_data");
    endtask

    task automatic test_busy_requests();
        for (int i = 0; i < 4; i++) do_write(8'($urandom), 2, 0, 1, "busy_noise");
    endtask

    task automatic test_reset_midwait();
        @(negedge clock); cs_n = 1'b1; we_n = 1'b1;
        @(posedge clock);
        @(negedge clock); cs_n = 1'b0; we_n = 1'b0; data_in = 8'h90; clock_enable = 1'b1;
        @(posedge clock); #1;
        tests++;
        if (obs !== exp_strobe(8'h90, model_lr) || ready !== 1'b0) begin
            fails++;
            $display("FAIL midwait_strobe: strobes=%b ready=%b, want %b 0", obs, ready, exp_strobe(8'h90, model_lr));
        end
        repeat (5) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        model_lr = 3'd0; model_bus = 8'h00;
        tests++;
        if (ready !== 1'b1 || obs !== 11'd0 || internal_data_bus !== 8'h00) begin
            fails++;
            $display("FAIL midwait_reset: ready=%b strobes=%b bus=%h, want 1/0/00", ready, obs, internal_data_bus);
        end
        @(negedge clock); reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            tests++;
            if (ready !== 1'b1 || obs !== 11'd0 || internal_data_bus !== 8'h00) begin
                fails++;
                $display("FAIL held_after_reset: ready=%b strobes=%b bus=%h, want 1/0/00", ready, obs, internal_data_bus);
            end
            @(negedge clock);
        end
        $display("[TB] reset_midwait: ready=%b bus=%h", ready, internal_data_bus);
        do_write(8'h3F, 0, 0, 0, "after_reset_data");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_write(8'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1) == 0 && i % 5 == 0),
                     1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_tone_freq();
        test_attenuation();
        test_noise();
        test_slow_ce_hold();
        test_busy_requests();
        test_reset_midwait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
